// File: rtl/rate_counter_pkg.sv
// Shared types and default rates for the rate-divided display counter.
package rate_counter_pkg;

    typedef enum logic [1:0] {
        FREQ_FULL       = 2'b00,
        FREQ_1HZ        = 2'b01,
        FREQ_HALF_HZ    = 2'b10,
        FREQ_QUARTER_HZ = 2'b11
    } freq_sel_t;

    localparam int unsigned CLK_HZ         = 50_000_000;
    localparam int unsigned DIV_1HZ        = CLK_HZ - 1;
    localparam int unsigned DIV_HALF_HZ    = 2 * CLK_HZ - 1;
    localparam int unsigned DIV_QUARTER_HZ = 4 * CLK_HZ - 1;

    // Reload value for the divider; the step period is reload + 1 enabled cycles.
    function automatic int unsigned div_reload(
        input freq_sel_t   sel,
        input int unsigned div_1,
        input int unsigned div_2,
        input int unsigned div_3
    );
        int unsigned r;
        r = 0;
        unique case (sel)
            FREQ_FULL:       r = 0;
            FREQ_1HZ:        r = div_1;
            FREQ_HALF_HZ:    r = div_2;
            FREQ_QUARTER_HZ: r = div_3;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/rate_tick_gen.sv
// Rate divider: counts enabled cycles down to zero and raises a step strobe.
// A rate change or parallel load restarts the period at the newly selected rate.
module rate_tick_gen
    import rate_counter_pkg::*;
#(
    parameter int unsigned DIV_W = 28,
    parameter int unsigned DIV_1 = DIV_1HZ,
    parameter int unsigned DIV_2 = DIV_HALF_HZ,
    parameter int unsigned DIV_3 = DIV_QUARTER_HZ
) (
    input  logic      clock,
    input  logic      reset,
    input  logic      enable,
    input  freq_sel_t freq,
    input  logic      par_load,
    output logic      step
);

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [DIV_W-1:0] sel_div;
    freq_sel_t        freq_q;
    logic             freq_chg;

    always_comb begin
        sel_div  = DIV_W'(div_reload(freq, DIV_1, DIV_2, DIV_3));
        freq_chg = (freq != freq_q);
        step     = enable && (div_cnt_q == '0) && !par_load && !freq_chg;
    end

    // Load and rate change reload even while disabled so the new period starts clean.
    always_comb begin
        div_cnt_d = div_cnt_q;
        if (par_load || freq_chg || step) begin
            div_cnt_d = sel_div;
        end else if (enable) begin
            div_cnt_d = div_cnt_q - DIV_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            div_cnt_q <= '0;
            freq_q    <= FREQ_FULL;
        end else begin
            div_cnt_q <= div_cnt_d;
            freq_q    <= freq;
        end
    end

endmodule

// File: rtl/rate_counter_param.sv
// Up/down display counter stepped by rate_tick_gen, with parallel load and wrap/saturate.
// Define RATE_COUNTER_LIMIT_EN to add a runtime upper bound input 'limit'.
module rate_counter_param
    import rate_counter_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DIV_W = 28,
    parameter int unsigned DIV_1 = DIV_1HZ,
    parameter int unsigned DIV_2 = DIV_HALF_HZ,
    parameter int unsigned DIV_3 = DIV_QUARTER_HZ
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic [1:0]       freq,
    input  logic             par_load,
    input  logic [WIDTH-1:0] load,
    input  logic             up_down,
    input  logic             sat,
`ifdef RATE_COUNTER_LIMIT_EN
    input  logic [WIDTH-1:0] limit,
`endif
    output logic [WIDTH-1:0] q,
    output logic             tick,
    output logic             wrap
);

    logic             step;
    logic [WIDTH-1:0] max_val;
    logic [WIDTH-1:0] q_q, q_d;
    logic             tick_q, tick_d;
    logic             wrap_q, wrap_d;

    rate_tick_gen #(
        .DIV_W (DIV_W),
        .DIV_1 (DIV_1),
        .DIV_2 (DIV_2),
        .DIV_3 (DIV_3)
    ) u_tick_gen (
        .clock    (clock),
        .reset    (reset),
        .enable   (enable),
        .freq     (freq_sel_t'(freq)),
        .par_load (par_load),
        .step     (step)
    );

`ifdef RATE_COUNTER_LIMIT_EN
    assign max_val = limit;
`else
    assign max_val = '1;
`endif

    // Up-count bound uses >= so a loaded value above the limit is treated as at the bound.
    always_comb begin
        q_d    = q_q;
        tick_d = 1'b0;
        wrap_d = 1'b0;
        if (par_load) begin
            q_d = load;
        end else if (step) begin
            tick_d = 1'b1;
            if (up_down) begin
                if (q_q >= max_val) begin
                    q_d    = sat ? max_val : '0;
                    wrap_d = !sat;
                end else begin
                    q_d = q_q + WIDTH'(1);
                end
            end else begin
                if (q_q == '0) begin
                    q_d    = sat ? '0 : max_val;
                    wrap_d = !sat;
                end else begin
                    q_d = q_q - WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            q_q    <= '0;
            tick_q <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            tick_q <= tick_d;
            wrap_q <= wrap_d;
        end
    end

    assign q    = q_q;
    assign tick = tick_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_rate_counter_param.sv
// Bench for rate_counter_param: directed scenarios plus randomized traffic against a reference model.
module tb_rate_counter_param;

    logic       clock;
    logic       reset;
    logic       enable;
    logic [1:0] freq;
    logic       par_load;
    logic [3:0] load;
    logic       up_down;
    logic       sat;
    logic [3:0] q;
    logic       tick;
    logic       wrap;
`ifdef RATE_COUNTER_LIMIT_EN
    logic [3:0] limit;
`endif

    int n_total = 0;
    int n_pass  = 0;

    rate_counter_param #(
        .WIDTH (4),
        .DIV_W (8),
        .DIV_1 (3),
        .DIV_2 (7),
        .DIV_3 (15)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .enable   (enable),
        .freq     (freq),
        .par_load (par_load),
        .load     (load),
        .up_down  (up_down),
        .sat      (sat),
`ifdef RATE_COUNTER_LIMIT_EN
        .limit    (limit),
`endif
        .q        (q),
        .tick     (tick),
        .wrap     (wrap)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act != exp) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        else n_pass++;
    endtask

    // Reference model: count enabled cycles left in the current period, step q in plain integers.
    int m_q = 0, m_tick = 0, m_wrap = 0, m_wait = 0, m_freq = 0, m_period = 1, m_max = 15, m_t = 0;

    function automatic int period_of(input int f);
        case (f)
            0: return 1;
            1: return 4;
            2: return 8;
            default: return 16;
        endcase
    endfunction

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_q = 0; m_tick = 0; m_wrap = 0; m_wait = 0; m_freq = 0;
        end else begin
`ifdef RATE_COUNTER_LIMIT_EN
            m_max = int'(limit);
`else
            m_max = 15;
`endif
            m_period = period_of(int'(freq));
            m_tick = 0;
            m_wrap = 0;
            if (par_load) begin
                m_q = int'(load);
                m_wait = m_period - 1;
            end else if (int'(freq) != m_freq) begin
                m_wait = m_period - 1;
            end else if (enable) begin
                if (m_wait == 0) begin
                    m_tick = 1;
                    m_t = up_down ? m_q + 1 : m_q - 1;
                    if (up_down && m_t > m_max) begin
                        m_q = sat ? m_max : 0;
                        m_wrap = sat ? 0 : 1;
                    end else if (!up_down && m_t < 0) begin
                        m_q = sat ? 0 : m_max;
                        m_wrap = sat ? 0 : 1;
                    end else begin
                        m_q = m_t;
                    end
                    m_wait = m_period - 1;
                end else begin
                    m_wait = m_wait - 1;
                end
            end
            m_freq = int'(freq);
        end
    end

    always @(negedge clock) begin
        if (!reset) begin
            check("model_q", int'(q), m_q);
            check("model_tick", int'(tick), m_tick);
            check("model_wrap", int'(wrap), m_wrap);
        end
    end

    task automatic nxt();
        @(posedge clock);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected bench completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; enable = 1'b0; freq = 2'd0; par_load = 1'b0; load = 4'd0;
        up_down = 1'b1; sat = 1'b0;
`ifdef RATE_COUNTER_LIMIT_EN
        limit = 4'd15;
`endif
        #3;
        check("reset_q", int'(q), 0);
        check("reset_tick", int'(tick), 0);
        check("reset_wrap", int'(wrap), 0);
        nxt();
        reset = 1'b0;

        // Async reset between edges mid-period, then count every cycle.
        par_load = 1'b1; load = 4'd9;
        nxt();
        check("s1_load9", int'(q), 9);
        par_load = 1'b0; freq = 2'd1; enable = 1'b1;
        nxt();
        nxt();
        #1 reset = 1'b1;
        #1;
        check("s1_async_q", int'(q), 0);
        check("s1_async_tick", int'(tick), 0);
        #1 reset = 1'b0;
        freq = 2'd0;
        for (int i = 1; i <= 3; i++) begin
            nxt();
            check("s1_count_q", int'(q), i);
            check("s1_count_tick", int'(tick), 1);
        end

        // Divide-by-4 up count wrapping from 15 to 0.
        freq = 2'd1; par_load = 1'b1; load = 4'd14;
        nxt();
        check("s2_load14", int'(q), 14);
        par_load = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            nxt();
            check("s2_q", int'(q), (i < 4) ? 14 : ((i < 8) ? 15 : 0));
            check("s2_tick", int'(tick), (i % 4 == 0) ? 1 : 0);
            check("s2_wrap", int'(wrap), (i == 8) ? 1 : 0);
        end

        // Down count saturating at 0, then wrapping to 15.
        freq = 2'd0; up_down = 1'b0; sat = 1'b1; par_load = 1'b1; load = 4'd1;
        nxt();
        par_load = 1'b0;
        for (int i = 0; i < 2; i++) begin
            nxt();
            check("s3_sat_q", int'(q), 0);
            check("s3_sat_tick", int'(tick), 1);
            check("s3_sat_wrap", int'(wrap), 0);
        end
        sat = 1'b0;
        nxt();
        check("s3_wrap_q", int'(q), 15);
        check("s3_wrap_flag", int'(wrap), 1);

        // Parallel load beats a due step and restarts the period.
        up_down = 1'b1; freq = 2'd1;
        nxt();
        check("s4_chg_tick", int'(tick), 0);
        for (int i = 0; i < 3; i++) begin
            nxt();
            check("s4_wait_tick", int'(tick), 0);
        end
        par_load = 1'b1; load = 4'd5;
        nxt();
        check("s4_load_q", int'(q), 5);
        check("s4_load_tick", int'(tick), 0);
        par_load = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            nxt();
            check("s4_next_tick", int'(tick), (i == 4) ? 1 : 0);
        end
        check("s4_next_q", int'(q), 6);

        // Rate change mid-period, then an enable gap stretching the period.
        nxt();
        freq = 2'd3;
        nxt();
        check("s5_chg_tick", int'(tick), 0);
        for (int i = 1; i <= 16; i++) begin
            nxt();
            check("s5_tick16", int'(tick), (i == 16) ? 1 : 0);
        end
        check("s5_q7", int'(q), 7);
        for (int i = 1; i <= 26; i++) begin
            enable = (i >= 6 && i <= 15) ? 1'b0 : 1'b1;
            nxt();
            check("s5_gap_tick", int'(tick), (i == 26) ? 1 : 0);
            if (i < 26) check("s5_gap_q", int'(q), 7);
        end
        check("s5_q8", int'(q), 8);

`ifdef RATE_COUNTER_LIMIT_EN
        limit = 4'd9; freq = 2'd0; up_down = 1'b1; sat = 1'b0; enable = 1'b1;
        par_load = 1'b1; load = 4'd8;
        nxt();
        par_load = 1'b0;
        nxt();
        check("lim_q9", int'(q), 9);
        nxt();
        check("lim_q0", int'(q), 0);
        check("lim_wrap", int'(wrap), 1);
        par_load = 1'b1; load = 4'd12;
        nxt();
        par_load = 1'b0;
        nxt();
        check("lim_over_q", int'(q), 0);
        check("lim_over_wrap", int'(wrap), 1);
`endif

        // Randomized traffic checked by the model every cycle.
        for (int n = 0; n < 3000; n++) begin
            enable = ($urandom_range(0, 99) < 85);
            if ($urandom_range(0, 19) == 0) freq = 2'($urandom_range(0, 3));
            par_load = ($urandom_range(0, 19) == 0);
            load = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 9) == 0) up_down = ~up_down;
            if ($urandom_range(0, 9) == 0) sat = 1'($urandom_range(0, 1));
`ifdef RATE_COUNTER_LIMIT_EN
            if ($urandom_range(0, 99) == 0) limit = 4'($urandom_range(0, 15));
`endif
            nxt();
            if ($urandom_range(0, 149) == 0) begin
                #1 reset = 1'b1;
                #1;
                check("rand_async_q", int'(q), 0);
                check("rand_async_tick", int'(tick), 0);
                #1 reset = 1'b0;
            end
        end

        @(posedge clock);
        #2;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
